// File: rtl/arg_extreme_stream.sv
// Streaming arg-min/arg-max over class-distance scores: a pipelined per-beat
// comparison tree followed by an accumulator that keeps the running best across beats.
module arg_extreme_stream #(
    parameter int LANES      = 8,
    parameter int DW         = 11,
    parameter int MAX_BEATS  = 4,
    parameter int REG_STRIDE = 2,
    localparam int IDXW      = $clog2(LANES * MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_mode,
    input  logic [LANES*DW-1:0]   in_vals,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    output logic [IDXW-1:0]       out_idx,
    output logic [DW-1:0]         out_val,
    output logic                  out_tie,
    output logic                  out_none,
    output logic                  out_err
);

    localparam int D  = $clog2(LANES);
    localparam int NP = 1 << D;
    localparam int LT = (D + REG_STRIDE - 1) / REG_STRIDE;
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [IDXW-1:0] LANES_W = IDXW'(LANES);
    localparam logic [CW-1:0]   MAXB_C  = CW'(MAX_BEATS);

    typedef struct packed {
        logic [DW-1:0]   val;
        logic [IDXW-1:0] idx;
        logic            tie;
        logic            part;
    } node_t;

    typedef node_t [NP-1:0] front_t;

    typedef struct packed {
        logic            valid;
        logic            first;
        logic            last;
        logic            mode;
        logic            err;
        logic [IDXW-1:0] base;
    } side_t;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    // Operand a always carries the lower index, so it keeps equal-value ties.
    function automatic node_t merge_node(input node_t a, input node_t b, input logic mode);
        node_t r;
        logic  b_better;
        b_better = mode ? (b.val > a.val) : (b.val < a.val);
        if (!b.part) begin
            r = a;
        end else if (!a.part) begin
            r = b;
        end else begin
            r = b_better ? b : a;
            if (a.val == b.val) begin
                r.tie = 1'b1;
            end else begin
                r.tie = r.tie;
            end
        end
        r.part = a.part | b.part;
        return r;
    endfunction

    // Collapses lv tree levels; entries beyond the live frontier are don't-care.
    function automatic front_t reduce_front(input front_t f, input int lv, input logic mode);
        front_t cur;
        front_t nxt;
        cur = f;
        for (int l = 0; l < lv; l++) begin
            nxt = cur;
            for (int n = 0; n < NP / 2; n++) begin
                nxt[n] = merge_node(cur[2*n], cur[2*n+1], mode);
            end
            cur = nxt;
        end
        return cur;
    endfunction

    function automatic int stage_levels(input int s);
        int hi;
        hi = (s * REG_STRIDE > D) ? D : s * REG_STRIDE;
        return hi - (s - 1) * REG_STRIDE;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] beat_cnt_s;
    logic          ovr_s;
    logic          grp_mode_r;
    side_t         sb0_s;
    front_t        fr0_s;
    front_t        fr_in_s [1:LT];
    front_t        fr_q    [1:LT];
    side_t         sb_q    [1:LT];

    // Beat numbering, overrun detection and leaf construction for the incoming beat.
    always_comb begin
        if (in_first) begin
            beat_cnt_s = '0;
        end else if (cnt_r >= MAXB_C) begin
            beat_cnt_s = MAXB_C;
        end else begin
            beat_cnt_s = cnt_r + CW'(1);
        end
        ovr_s       = (beat_cnt_s >= MAXB_C);
        sb0_s.valid = in_valid;
        sb0_s.first = in_first;
        sb0_s.last  = in_last;
        sb0_s.mode  = in_first ? in_mode : grp_mode_r;
        sb0_s.err   = ovr_s;
        sb0_s.base  = ovr_s ? '0 : IDXW'(beat_cnt_s) * LANES_W;
        for (int i = 0; i < NP; i++) begin
            int li;
            li = (i < LANES) ? i : 0;
            fr0_s[i].idx = IDXW'(i);
            fr0_s[i].tie = 1'b0;
            if (i < LANES) begin
                fr0_s[i].val  = in_vals[li*DW +: DW];
                fr0_s[i].part = in_mask[li] & ~ovr_s;
            end else begin
                fr0_s[i].val  = '0;
                fr0_s[i].part = 1'b0;
            end
        end
    end

    // Beat counter and the group mode used for follow-on beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            grp_mode_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r <= beat_cnt_s;
            if (in_first) begin
                grp_mode_r <= in_mode;
            end else begin
                grp_mode_r <= grp_mode_r;
            end
        end
    end

    // Per-stage tree slices; each stage uses the mode of the beat it currently holds.
    always_comb begin
        fr_in_s[1] = reduce_front(fr0_s, stage_levels(1), sb0_s.mode);
        for (int s = 2; s <= LT; s++) begin
            fr_in_s[s] = reduce_front(fr_q[s-1], stage_levels(s), sb_q[s-1].mode);
        end
    end

    // Tree pipeline registers with side-band travelling alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= LT; s++) begin
                fr_q[s] <= '0;
                sb_q[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= LT; s++) begin
                fr_q[s] <= fr_in_s[s];
            end
            sb_q[1] <= sb0_s;
            for (int s = 2; s <= LT; s++) begin
                sb_q[s] <= sb_q[s-1];
            end
        end
    end

    state_t    state_r;
    node_t     best_r;
    logic      err_r;
    logic      acc_mode_r;
    side_t     tail_s;
    node_t     beat_s;
    node_t     merge_s;
    node_t     nxt_best_s;
    logic      nxt_err_s;
    logic      take_s;

    logic            out_valid_r;
    logic [IDXW-1:0] out_idx_r;
    logic [DW-1:0]   out_val_r;
    logic            out_tie_r;
    logic            out_none_r;
    logic            out_err_r;

    // Beat result in global index space and its merge with the running best.
    always_comb begin
        tail_s     = sb_q[LT];
        beat_s     = fr_q[LT][0];
        beat_s.idx = tail_s.base + fr_q[LT][0].idx;
        merge_s    = merge_node(best_r, beat_s, acc_mode_r);
        if (tail_s.first) begin
            nxt_best_s = beat_s;
            nxt_err_s  = tail_s.err;
        end else begin
            nxt_best_s = merge_s;
            nxt_err_s  = err_r | tail_s.err;
        end
        case (state_r)
            IDLE:    take_s = tail_s.valid & tail_s.first;
            ACCUM:   take_s = tail_s.valid;
            default: take_s = 1'b0;
        endcase
    end

    // Accumulator FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            best_r      <= '0;
            err_r       <= 1'b0;
            acc_mode_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= '0;
            out_val_r   <= '0;
            out_tie_r   <= 1'b0;
            out_none_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (take_s) begin
                best_r <= nxt_best_s;
                err_r  <= nxt_err_s;
                if (tail_s.first) begin
                    acc_mode_r <= tail_s.mode;
                end
                if (tail_s.last) begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b1;
                    out_idx_r   <= nxt_best_s.part ? nxt_best_s.idx : '0;
                    out_val_r   <= nxt_best_s.part ? nxt_best_s.val : '0;
                    out_tie_r   <= nxt_best_s.part & nxt_best_s.tie;
                    out_none_r  <= ~nxt_best_s.part;
                    out_err_r   <= nxt_err_s;
                end else begin
                    state_r <= ACCUM;
                end
            end else begin
                case (state_r)
                    IDLE:    state_r <= IDLE;
                    ACCUM:   state_r <= ACCUM;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_val   = out_val_r;
    assign out_tie   = out_tie_r;
    assign out_none  = out_none_r;
    assign out_err   = out_err_r;

endmodule
